// File: rtl/axis_pixel_pack_pkg.sv
// Shared pixel/word types and geometry defaults for the pixel packing output stage.
package axis_pixel_pack_pkg;
  localparam int PIX_W     = 8;
  localparam int LANES     = 4;
  localparam int OUT_W     = LANES * PIX_W;
  localparam int IMG_W_DEF = 640;
  localparam int IMG_H_DEF = 480;

  typedef logic [PIX_W-1:0] pixel_t;
  typedef logic [OUT_W-1:0] word_t;

  function automatic int cntWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/axis_pixel_pack_if.sv
// AXI4-Stream style bundle (data, valid, ready, last) shared by the pixel input and word output.
interface axis_pixel_pack_if #(parameter int W = 8);
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;
  logic         tlast;

  modport master (output tdata, tvalid, tlast, input tready);
  modport slave  (input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/axis_pixel_pack_word_reg.sv
// One-entry AXIS output register: holds data/last stable while valid is stalled by ready.
module axis_pixel_pack_word_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [W-1:0] in_data_i,
  input  logic         in_last_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [W-1:0] out_data_o,
  output logic         out_last_o
);
  logic         valid_q;
  logic [W-1:0] data_q;
  logic         last_q;

  assign in_ready_o  = !valid_q || out_ready_i;
  assign out_valid_o = valid_q;
  assign out_data_o  = data_q;
  assign out_last_o  = last_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else if (in_valid_i && in_ready_o) begin
      valid_q <= 1'b1;
      data_q  <= in_data_i;
      last_q  <= in_last_i;
    end else if (out_ready_i) begin
      valid_q <= 1'b0;
    end
  end
endmodule

// File: rtl/axis_pixel_pack.sv
// Packs LANES pixels per beat into the DMA-facing word stream, tracks frame geometry,
// regenerates tlast at frame end and flags short/long frames from upstream.
module axis_pixel_pack
  import axis_pixel_pack_pkg::*;
#(
  parameter int IMG_W = IMG_W_DEF,
  parameter int IMG_H = IMG_H_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  axis_pixel_pack_if.slave        axis_i,
  axis_pixel_pack_if.master       axis_o,
  output logic                    frame_done,
  output logic                    err_short,
  output logic                    err_long,
  output logic [15:0]             frame_cnt
);
  localparam int CW = cntWidth(IMG_W);
  localparam int RW = cntWidth(IMG_H);
  localparam int LW = cntWidth(LANES);

  logic [LW-1:0] lane_q, lane_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  word_t         pack_q, pack_d;
  logic          frameDone_q, frameDone_d;
  logic          errShort_q, errShort_d;
  logic          errLong_q, errLong_d;
  logic [15:0]   frameCnt_q, frameCnt_d;

  logic          regReady;
  logic          accept;
  logic          geoFinal;
  logic          frameEnd;
  logic          wordDone;
  logic          outLastHs;
  pixel_t        pix;
  word_t         wordNext;

  assign pix       = pixel_t'(axis_i.tdata);
  assign axis_i.tready = !rst && regReady;
  assign accept    = axis_i.tvalid && axis_i.tready;
  assign geoFinal  = (col_q == CW'(IMG_W - 1)) && (row_q == RW'(IMG_H - 1));
  assign frameEnd  = geoFinal || axis_i.tlast;
  assign wordDone  = (lane_q == LW'(LANES - 1)) || frameEnd;
  assign outLastHs = axis_o.tvalid && axis_o.tready && axis_o.tlast;
  // Lanes above the current one are still zero in pack_q, which gives free zero padding.
  assign wordNext  = pack_q | (word_t'(pix) << (PIX_W * int'(lane_q)));

  always_comb begin
    lane_d      = lane_q;
    col_d       = col_q;
    row_d       = row_q;
    pack_d      = pack_q;
    errShort_d  = accept && axis_i.tlast && !geoFinal;
    errLong_d   = accept && geoFinal && !axis_i.tlast;
    frameDone_d = outLastHs;
    frameCnt_d  = frameCnt_q + 16'(outLastHs);
    if (accept) begin
      if (frameEnd) begin
        lane_d = '0;
        col_d  = '0;
        row_d  = '0;
        pack_d = '0;
      end else begin
        lane_d = wordDone ? '0 : lane_q + LW'(1);
        pack_d = wordDone ? '0 : wordNext;
        if (col_q == CW'(IMG_W - 1)) begin
          col_d = '0;
          row_d = row_q + RW'(1);
        end else begin
          col_d = col_q + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_q      <= '0;
      col_q       <= '0;
      row_q       <= '0;
      pack_q      <= '0;
      frameDone_q <= 1'b0;
      errShort_q  <= 1'b0;
      errLong_q   <= 1'b0;
      frameCnt_q  <= '0;
    end else begin
      lane_q      <= lane_d;
      col_q       <= col_d;
      row_q       <= row_d;
      pack_q      <= pack_d;
      frameDone_q <= frameDone_d;
      errShort_q  <= errShort_d;
      errLong_q   <= errLong_d;
      frameCnt_q  <= frameCnt_d;
    end
  end

  assign frame_done = frameDone_q;
  assign err_short  = errShort_q;
  assign err_long   = errLong_q;
  assign frame_cnt  = frameCnt_q;

  axis_pixel_pack_word_reg #(.W(OUT_W)) u_word_reg (
    .clk         (clk),
    .rst         (rst),
    .in_valid_i  (accept && wordDone),
    .in_ready_o  (regReady),
    .in_data_i   (wordNext),
    .in_last_i   (frameEnd),
    .out_valid_o (axis_o.tvalid),
    .out_ready_i (axis_o.tready),
    .out_data_o  (axis_o.tdata),
    .out_last_o  (axis_o.tlast)
  );
endmodule

// File: tb/tb_axis_pixel_pack.sv
// Scoreboard bench: instance A is 4x2 pixels, instance B is 3x2 pixels, both 4 lanes of 8 bits.
module tb_axis_pixel_pack;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axis_pixel_pack_if #(.W(8))  inA ();
  axis_pixel_pack_if #(.W(32)) outA ();
  axis_pixel_pack_if #(.W(8))  inB ();
  axis_pixel_pack_if #(.W(32)) outB ();

  logic        doneA, shortA, longA, doneB, shortB, longB;
  logic [15:0] cntA, cntB;

  axis_pixel_pack #(.IMG_W(4), .IMG_H(2)) dutA (
    .clk(clk), .rst(rst), .axis_i(inA), .axis_o(outA),
    .frame_done(doneA), .err_short(shortA), .err_long(longA), .frame_cnt(cntA)
  );
  axis_pixel_pack #(.IMG_W(3), .IMG_H(2)) dutB (
    .clk(clk), .rst(rst), .axis_i(inB), .axis_o(outB),
    .frame_done(doneB), .err_short(shortB), .err_long(longB), .frame_cnt(cntB)
  );

  int nChecks = 0;
  int nPass   = 0;
  logic [32:0] qA[$];
  logic [32:0] qB[$];
  int expCntA = 0, expCntB = 0, expDoneA = 0, expDoneB = 0;
  int nDoneA = 0, nShortA = 0, nLongA = 0, nDoneB = 0, nShortB = 0, nLongB = 0;
  bit randReady = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act === exp) nPass++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic pushExp(input bit useB, input logic [31:0] data, input logic last);
    if (useB) begin
      qB.push_back({last, data});
      if (last) begin expCntB++; expDoneB++; end
    end else begin
      qA.push_back({last, data});
      if (last) begin expCntA++; expDoneA++; end
    end
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that accepted the pixel.
  task automatic applyStimulus(input bit useB, input logic [7:0] p, input logic l);
    int n;
    if (useB) begin inB.tdata = p; inB.tlast = l; inB.tvalid = 1'b1; end
    else      begin inA.tdata = p; inA.tlast = l; inA.tvalid = 1'b1; end
    n = 0;
    do begin @(negedge clk); n++; end
    while (!(useB ? inB.tready : inA.tready) && n < 300);
    if (!(useB ? inB.tready : inA.tready)) begin
      nChecks++;
      $display("[TB] FAIL input_accept_timeout: pixel %0h never accepted", p);
    end
    @(posedge clk); #1;
    inA.tvalid = 1'b0; inA.tlast = 1'b0;
    inB.tvalid = 1'b0; inB.tlast = 1'b0;
  endtask

  task automatic waitDrain();
    int n = 0;
    while ((qA.size() != 0 || qB.size() != 0 || outA.tvalid || outB.tvalid) && n < 1000) begin
      @(negedge clk); n++;
    end
    if (n >= 1000) begin
      nChecks++;
      $display("[TB] FAIL drain_timeout: %0d words of A and %0d of B still pending", qA.size(), qB.size());
    end
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic doReset(input string name);
    rst = 1'b1;
    inA.tvalid = 1'b0; inA.tlast = 1'b0; inA.tdata = '0;
    inB.tvalid = 1'b0; inB.tlast = 1'b0; inB.tdata = '0;
    @(negedge clk); @(negedge clk);
    checkOutput({name, "_A"}, {cntA, 13'(0), outA.tvalid, outA.tlast, inA.tready, doneA, shortA, longA, outA.tdata}, 64'h0);
    checkOutput({name, "_B"}, {cntB, 13'(0), outB.tvalid, outB.tlast, inB.tready, doneB, shortB, longB, outB.tdata}, 64'h0);
    qA.delete(); qB.delete();
    expCntA = 0; expCntB = 0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Output ready changes only just after a rising edge so negedge samples see a stable handshake.
  initial begin
    outA.tready = 1'b1;
    outB.tready = 1'b1;
    forever begin
      @(posedge clk); #1;
      outA.tready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pops the scoreboard on every output handshake and checks stall stability.
  initial begin
    logic [32:0] e, holdA, holdB;
    bit stallA = 1'b0, stallB = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stallA = 1'b0; stallB = 1'b0;
      end else begin
        if (stallA) checkOutput("stall_hold_A", {outA.tvalid, outA.tlast, outA.tdata}, {1'b1, holdA});
        if (stallB) checkOutput("stall_hold_B", {outB.tvalid, outB.tlast, outB.tdata}, {1'b1, holdB});
        if (outA.tvalid && outA.tready) begin
          if (qA.size() == 0) begin
            nChecks++;
            $display("[TB] FAIL unexpected_word_A: got %0h with last %0b, none expected", outA.tdata, outA.tlast);
          end else begin
            e = qA.pop_front();
            checkOutput("word_A", {outA.tlast, outA.tdata}, e);
          end
        end
        if (outB.tvalid && outB.tready) begin
          if (qB.size() == 0) begin
            nChecks++;
            $display("[TB] FAIL unexpected_word_B: got %0h with last %0b, none expected", outB.tdata, outB.tlast);
          end else begin
            e = qB.pop_front();
            checkOutput("word_B", {outB.tlast, outB.tdata}, e);
          end
        end
        stallA = outA.tvalid && !outA.tready; holdA = {outA.tlast, outA.tdata};
        stallB = outB.tvalid && !outB.tready; holdB = {outB.tlast, outB.tdata};
        nDoneA += int'(doneA); nShortA += int'(shortA); nLongA += int'(longA);
        nDoneB += int'(doneB); nShortB += int'(shortB); nLongB += int'(longB);
      end
    end
  end

  task automatic checkCounts(input string name, input int eShortA, input int eLongA);
    checkOutput({name, "_frame_cnt_A"},  64'(cntA), 64'(expCntA));
    checkOutput({name, "_frame_done_A"}, 64'(nDoneA), 64'(expDoneA));
    checkOutput({name, "_err_short_A"},  64'(nShortA), 64'(eShortA));
    checkOutput({name, "_err_long_A"},   64'(nLongA), 64'(eLongA));
  endtask

  initial begin
    logic [31:0] acc;
    logic [7:0]  p;
    inA.tvalid = 1'b0; inA.tlast = 1'b0; inA.tdata = '0;
    inB.tvalid = 1'b0; inB.tlast = 1'b0; inB.tdata = '0;
    doReset("reset_state");

    $display("[TB] test 1: normal 4x2 frame");
    pushExp(0, 32'h04030201, 1'b0);
    pushExp(0, 32'h08070605, 1'b1);
    for (int i = 1; i <= 8; i++) applyStimulus(0, 8'(i), i == 8);
    waitDrain();
    checkCounts("t1", 0, 0);

    $display("[TB] test 2: 3x2 frame with zero padded final word");
    pushExp(1, 32'h14131211, 1'b0);
    pushExp(1, 32'h00001615, 1'b1);
    for (int i = 1; i <= 6; i++) applyStimulus(1, 8'(8'h10 + i), i == 6);
    waitDrain();
    checkOutput("t2_frame_cnt_B",  64'(cntB), 64'(expCntB));
    checkOutput("t2_frame_done_B", 64'(nDoneB), 64'(expDoneB));
    checkOutput("t2_errors_B",     64'(nShortB + nLongB), 64'(0));

    $display("[TB] test 3: short frame then normal frame");
    pushExp(0, 32'h00A3A2A1, 1'b1);
    applyStimulus(0, 8'hA1, 1'b0);
    applyStimulus(0, 8'hA2, 1'b0);
    applyStimulus(0, 8'hA3, 1'b1);
    pushExp(0, 32'h34333231, 1'b0);
    pushExp(0, 32'h38373635, 1'b1);
    for (int i = 1; i <= 8; i++) applyStimulus(0, 8'(8'h30 + i), i == 8);
    waitDrain();
    checkCounts("t3", 1, 0);

    $display("[TB] test 4: long frame without tlast");
    pushExp(0, 32'h24232221, 1'b0);
    pushExp(0, 32'h28272625, 1'b1);
    pushExp(0, 32'h2C2B2A29, 1'b0);
    pushExp(0, 32'h302F2E2D, 1'b1);
    for (int i = 1; i <= 16; i++) applyStimulus(0, 8'(8'h20 + i), i == 16);
    waitDrain();
    checkCounts("t4", 1, 1);

    $display("[TB] test 5: 20 frames with random stalls and gaps");
    expCntA = 0;
    doReset("t5_reset");
    randReady = 1'b1;
    for (int f = 0; f < 20; f++) begin
      acc = '0;
      for (int i = 0; i < 8; i++) begin
        p = 8'(f * 8 + i + 8'h40);
        acc[(i % 4) * 8 +: 8] = p;
        if (i % 4 == 3) begin
          pushExp(0, acc, i == 7);
          acc = '0;
        end
        if ($urandom_range(0, 2) == 0) begin
          repeat ($urandom_range(1, 3)) @(posedge clk);
          #1;
        end
        applyStimulus(0, p, i == 7);
      end
    end
    randReady = 1'b0;
    waitDrain();
    checkOutput("t5_frame_cnt_20", 64'(cntA), 64'(20));
    checkCounts("t5", 1, 1);

    $display("[TB] test 6: reset mid frame then full frame");
    pushExp(0, 32'h04030201, 1'b0);
    for (int i = 1; i <= 5; i++) applyStimulus(0, 8'(i), 1'b0);
    repeat (3) @(posedge clk);
    #1;
    doReset("t6_reset");
    pushExp(0, 32'h04030201, 1'b0);
    pushExp(0, 32'h08070605, 1'b1);
    for (int i = 1; i <= 8; i++) applyStimulus(0, 8'(i), i == 8);
    waitDrain();
    checkOutput("t6_frame_cnt_1", 64'(cntA), 64'(1));
    checkCounts("t6", 1, 1);

    $display("[TB] %0d/%0d checks passed", nPass, nChecks);
    $finish;
  end
endmodule
